// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared constants and types for the FPU issue sequencer: operation and exception
// codes, special-result constants, FSM state encoding and status flag bit positions.
package fpu_issue_ctrl_pkg;

    localparam logic [1:0] ADDITION       = 2'd0;
    localparam logic [1:0] SUBTRACTION    = 2'd1;
    localparam logic [1:0] MULTIPLICATION = 2'd2;
    localparam logic [1:0] DIVISION       = 2'd3;

    localparam logic [2:0] NO_EXCE       = 3'd0;
    localparam logic [2:0] ZERO_DIV_EXCE = 3'd1;
    localparam logic [2:0] QNAN_EXCE     = 3'd2;
    localparam logic [2:0] SNAN_EXCE     = 3'd3;
    localparam logic [2:0] INF_EXCE      = 3'd4;

    localparam logic [7:0] CANON_QNAN = 8'h7C;
    localparam logic [6:0] INF_MAG    = 7'h78;

    typedef enum logic [1:0] {
        ISS_IDLE  = 2'd0,
        ISS_CHECK = 2'd1,
        ISS_EXEC  = 2'd2,
        ISS_RESP  = 2'd3
    } iss_state_e;

    localparam int FLG_INVALID  = 0;
    localparam int FLG_DIV_ZERO = 1;
    localparam int FLG_NAN_IN   = 2;
    localparam int FLG_ANY      = 3;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } iss_req_t;

endpackage

// File: rtl/fpu_issue_ctrl_special_result.sv
// Combinational special-result generator: maps an exception code and operands to the
// forced result and the set of status flags that exception raises.
module fpu_special_result
    import fpu_issue_ctrl_pkg::*;
(
    input  logic [2:0] fp_exce,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] special_value,
    output logic [3:0] flag_set
);

    // Only the sign of B matters for the infinity result.
    logic unused_b_mag;
    assign unused_b_mag = ^op_b[6:0];

    always_comb begin
        special_value     = CANON_QNAN;
        flag_set          = '0;
        flag_set[FLG_ANY] = 1'b1;
        case (fp_exce)
            QNAN_EXCE: flag_set[FLG_NAN_IN] = 1'b1;
            SNAN_EXCE,
            INF_EXCE:  flag_set[FLG_INVALID] = 1'b1;
            ZERO_DIV_EXCE: begin
                // 0/0 is invalid and yields NaN; x/0 yields signed infinity.
                if (op_a[6:0] == 7'd0) begin
                    flag_set[FLG_INVALID] = 1'b1;
                end else begin
                    special_value          = {op_a[7] ^ op_b[7], INF_MAG};
                    flag_set[FLG_DIV_ZERO] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the 8-bit FPU: request capture, exception screening, core launch
// and response hold. Sticky status flags are built only with FPU_STICKY_FLAGS_EN.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] FP_OPERATION,
    input  logic [7:0] OP_A,
    input  logic [7:0] OP_B,
    output logic [1:0] EXC_FP_OPERATION,
    output logic [7:0] EXC_OP_A,
    output logic [7:0] EXC_OP_B,
    input  logic       OP_IS_EXCEPTION,
    input  logic [2:0] FP_EXCE,
    output logic       CORE_START,
    input  logic       CORE_DONE,
    input  logic [7:0] CORE_RESULT,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [7:0] RESULT,
    output logic [2:0] RES_EXCE,
    output logic [3:0] STATUS_FLAGS,
    input  logic       FLAGS_CLR
);

    iss_state_e state_q, state_d;
    iss_req_t   req_q;
    logic       core_start_q;
    logic [7:0] result_q;
    logic [2:0] res_exce_q;

    logic       accept, load_special, load_core, launch;
    logic [7:0] special_value;
    logic [3:0] flag_set;

    fpu_special_result u_special (
        .fp_exce       (FP_EXCE),
        .op_a          (req_q.a),
        .op_b          (req_q.b),
        .special_value (special_value),
        .flag_set      (flag_set)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ISS_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        REQ_READY    = 1'b0;
        RES_VALID    = 1'b0;
        accept       = 1'b0;
        load_special = 1'b0;
        load_core    = 1'b0;
        launch       = 1'b0;
        case (state_q)
            ISS_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    accept  = 1'b1;
                    state_d = ISS_CHECK;
                end
            end
            ISS_CHECK: begin
                if (OP_IS_EXCEPTION) begin
                    load_special = 1'b1;
                    state_d      = ISS_RESP;
                end else begin
                    launch  = 1'b1;
                    state_d = ISS_EXEC;
                end
            end
            ISS_EXEC: begin
                if (CORE_DONE) begin
                    load_core = 1'b1;
                    state_d   = ISS_RESP;
                end
            end
            ISS_RESP: begin
                RES_VALID = 1'b1;
                if (RES_READY) state_d = ISS_IDLE;
            end
            default: state_d = ISS_IDLE;
        endcase
    end

    // Launch pulse is registered so it lands exactly in the first EXEC cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q        <= '0;
            core_start_q <= 1'b0;
            result_q     <= 8'h00;
            res_exce_q   <= NO_EXCE;
        end else begin
            core_start_q <= launch;
            if (accept) begin
                req_q.op <= FP_OPERATION;
                req_q.a  <= OP_A;
                req_q.b  <= OP_B;
            end
            if (load_special) begin
                result_q   <= special_value;
                res_exce_q <= FP_EXCE;
            end else if (load_core) begin
                result_q   <= CORE_RESULT;
                res_exce_q <= NO_EXCE;
            end
        end
    end

    assign EXC_FP_OPERATION = req_q.op;
    assign EXC_OP_A         = req_q.a;
    assign EXC_OP_B         = req_q.b;
    assign CORE_START       = core_start_q;
    assign RESULT           = result_q;
    assign RES_EXCE         = res_exce_q;

`ifdef FPU_STICKY_FLAGS_EN
    logic [3:0] flags_q;

    // Clear first, then OR in this cycle's sets so a coincident set survives.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) flags_q <= 4'h0;
        else        flags_q <= (FLAGS_CLR ? 4'h0 : flags_q) | (load_special ? flag_set : 4'h0);
    end

    assign STATUS_FLAGS = flags_q;
`else
    logic unused_flags;
    assign unused_flags = FLAGS_CLR ^ (^flag_set);
    assign STATUS_FLAGS = 4'h0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: table of single operations plus hand-written
// backpressure and mid-operation reset sequences.
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_VALID, REQ_READY;
    logic [1:0] FP_OPERATION, EXC_FP_OPERATION;
    logic [7:0] OP_A, OP_B, EXC_OP_A, EXC_OP_B;
    logic       OP_IS_EXCEPTION;
    logic [2:0] FP_EXCE;
    logic       CORE_START, CORE_DONE;
    logic [7:0] CORE_RESULT;
    logic       RES_VALID, RES_READY;
    logic [7:0] RESULT;
    logic [2:0] RES_EXCE;
    logic [3:0] STATUS_FLAGS;
    logic       FLAGS_CLR;

    fpu_issue_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
        .EXC_FP_OPERATION(EXC_FP_OPERATION), .EXC_OP_A(EXC_OP_A), .EXC_OP_B(EXC_OP_B),
        .OP_IS_EXCEPTION(OP_IS_EXCEPTION), .FP_EXCE(FP_EXCE),
        .CORE_START(CORE_START), .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RESULT(RESULT), .RES_EXCE(RES_EXCE),
        .STATUS_FLAGS(STATUS_FLAGS), .FLAGS_CLR(FLAGS_CLR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b;
        logic       is_exc;
        logic [2:0] exce;
        int         core_lat;
        logic [7:0] core_res;
        logic       clr;
        int         hold;
        logic [7:0] exp_res;
        logic [2:0] exp_exce;
        logic [3:0] exp_flags;
        int         exp_lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] flg(input logic [3:0] f);
`ifdef FPU_STICKY_FLAGS_EN
        return f;
`else
        return 4'h0 & f;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic is_exc, input logic [2:0] exce, input int core_lat,
                                input logic [7:0] core_res, input logic clr, input int hold,
                                input logic [7:0] exp_res, input logic [2:0] exp_exce,
                                input logic [3:0] exp_flags, input int exp_lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.is_exc = is_exc; v.exce = exce;
        v.core_lat = core_lat; v.core_res = core_res; v.clr = clr; v.hold = hold;
        v.exp_res = exp_res; v.exp_exce = exp_exce; v.exp_flags = exp_flags; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Cycle numbering: the negedge before the request handshake edge is cycle 0.
    task automatic run_vec(input int idx, input vec_t v);
        int starts;
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        chk({tag, "_req_ready_idle"}, REQ_READY, 1);
        REQ_VALID = 1'b1; FP_OPERATION = v.op; OP_A = v.a; OP_B = v.b;
        OP_IS_EXCEPTION = v.is_exc; FP_EXCE = v.exce;
        @(negedge CLK);
        REQ_VALID = 1'b0; FLAGS_CLR = v.clr;
        chk({tag, "_exc_op"}, {EXC_FP_OPERATION, EXC_OP_A, EXC_OP_B}, {v.op, v.a, v.b});
        chk({tag, "_req_ready_busy"}, REQ_READY, 0);
        starts = 0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge CLK);
            if (c == 2) FLAGS_CLR = 1'b0;
            CORE_DONE = 1'b0;
            if (CORE_START) starts++;
            if (RES_VALID) begin lat = c; break; end
            if (!v.is_exc && c == 2 + v.core_lat) begin
                CORE_DONE = 1'b1; CORE_RESULT = v.core_res;
            end
        end
        CORE_DONE = 1'b0; FLAGS_CLR = 1'b0;
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_result"}, RESULT, v.exp_res);
        chk({tag, "_res_exce"}, RES_EXCE, v.exp_exce);
        chk({tag, "_flags"}, STATUS_FLAGS, flg(v.exp_flags));
        chk({tag, "_core_starts"}, starts, v.is_exc ? 0 : 1);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge CLK);
            chk({tag, "_hold"}, {RES_VALID, RESULT, RES_EXCE}, {1'b1, v.exp_res, v.exp_exce});
        end
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        chk({tag, "_post_resp"}, {RES_VALID, REQ_READY}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0; REQ_VALID = 1'b0; FP_OPERATION = ADDITION; OP_A = 8'h00; OP_B = 8'h00;
        OP_IS_EXCEPTION = 1'b0; FP_EXCE = NO_EXCE; CORE_DONE = 1'b0; CORE_RESULT = 8'h00;
        RES_READY = 1'b0; FLAGS_CLR = 1'b0;

        //            op              a      b      exc  code           lat res    clr hold exp_res exp_exce       flags    lat
        vecs[0]  = mk(ADDITION,       8'h78, 8'hF8, 1, INF_EXCE,      0, 8'h00, 0, 2, 8'h7C, INF_EXCE,      4'b1001, 2);
        vecs[1]  = mk(DIVISION,       8'hB8, 8'h00, 1, ZERO_DIV_EXCE, 0, 8'h00, 1, 0, 8'hF8, ZERO_DIV_EXCE, 4'b1010, 2);
        vecs[2]  = mk(DIVISION,       8'h00, 8'h00, 1, ZERO_DIV_EXCE, 0, 8'h00, 1, 0, 8'h7C, ZERO_DIV_EXCE, 4'b1001, 2);
        vecs[3]  = mk(ADDITION,       8'h38, 8'h38, 0, NO_EXCE,       3, 8'h40, 0, 1, 8'h40, NO_EXCE,       4'b1001, 6);
        vecs[4]  = mk(MULTIPLICATION, 8'h12, 8'h34, 1, QNAN_EXCE,     0, 8'h00, 0, 0, 8'h7C, QNAN_EXCE,     4'b1101, 2);
        vecs[5]  = mk(DIVISION,       8'h38, 8'h00, 1, ZERO_DIV_EXCE, 0, 8'h00, 1, 0, 8'h78, ZERO_DIV_EXCE, 4'b1010, 2);
        vecs[6]  = mk(SUBTRACTION,    8'h40, 8'h38, 0, NO_EXCE,       0, 8'h5A, 0, 0, 8'h5A, NO_EXCE,       4'b1010, 3);
        vecs[7]  = mk(DIVISION,       8'h7D, 8'h01, 1, SNAN_EXCE,     0, 8'h00, 0, 0, 8'h7C, SNAN_EXCE,     4'b1011, 2);
        vecs[8]  = mk(DIVISION,       8'h80, 8'h08, 1, ZERO_DIV_EXCE, 0, 8'h00, 0, 0, 8'h7C, ZERO_DIV_EXCE, 4'b1011, 2);
        vecs[9]  = mk(DIVISION,       8'hC0, 8'h80, 1, ZERO_DIV_EXCE, 0, 8'h00, 0, 0, 8'h78, ZERO_DIV_EXCE, 4'b1011, 2);
        vecs[10] = mk(MULTIPLICATION, 8'h3C, 8'hC4, 0, NO_EXCE,       1, 8'hC3, 1, 3, 8'hC3, NO_EXCE,       4'b0000, 4);

        repeat (2) @(negedge CLK);
        chk("reset_state", {REQ_READY, RES_VALID, CORE_START, RESULT, RES_EXCE, EXC_OP_A, EXC_OP_B,
                            EXC_FP_OPERATION, STATUS_FLAGS},
            {1'b1, 1'b0, 1'b0, 8'h00, NO_EXCE, 8'h00, 8'h00, 2'b00, 4'h0});
        RST_N = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Backpressure: response held while a new request waits.
        @(negedge CLK);
        REQ_VALID = 1'b1; FP_OPERATION = ADDITION; OP_A = 8'h78; OP_B = 8'hF8;
        OP_IS_EXCEPTION = 1'b1; FP_EXCE = INF_EXCE;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("bp_res_valid", RES_VALID, 1);
        REQ_VALID = 1'b1; FP_OPERATION = MULTIPLICATION; OP_A = 8'h11; OP_B = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_stall", {REQ_READY, RES_VALID, RESULT, RES_EXCE, EXC_OP_A},
                {1'b0, 1'b1, 8'h7C, INF_EXCE, 8'h78});
        end
        FP_EXCE = QNAN_EXCE;
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        chk("bp_idle_gap", {REQ_READY, RES_VALID, EXC_OP_A}, {1'b1, 1'b0, 8'h78});
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("bp_accepted", {REQ_READY, EXC_FP_OPERATION, EXC_OP_A, EXC_OP_B},
            {1'b0, MULTIPLICATION, 8'h11, 8'h22});
        @(negedge CLK);
        chk("bp_second_resp", {RES_VALID, RESULT, RES_EXCE}, {1'b1, 8'h7C, QNAN_EXCE});
        chk("bp_flags", STATUS_FLAGS, flg(4'b1101));
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;

        // Reset during EXEC, then a stale CORE_DONE.
        @(negedge CLK);
        REQ_VALID = 1'b1; FP_OPERATION = ADDITION; OP_A = 8'h38; OP_B = 8'h38;
        OP_IS_EXCEPTION = 1'b0; FP_EXCE = NO_EXCE;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("rst_core_start", CORE_START, 1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_async", {REQ_READY, RES_VALID, CORE_START, RESULT, RES_EXCE, EXC_OP_A, STATUS_FLAGS},
            {1'b1, 1'b0, 1'b0, 8'h00, NO_EXCE, 8'h00, 4'h0});
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        CORE_DONE = 1'b1; CORE_RESULT = 8'h99;
        @(negedge CLK);
        CORE_DONE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rst_stale_done", {REQ_READY, RES_VALID, CORE_START, RESULT, RES_EXCE},
                {1'b1, 1'b0, 1'b0, 8'h00, NO_EXCE});
            @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencer in front of the 8-bit FPU datapath. It accepts one operation at a time over a valid/ready request port and registers the operands. It runs them past the exception checker, then either forces a special result directly or launches the arithmetic core and waits for it. The result is presented on a valid/ready response port, together with the exception code and sticky status flags.

## Interface
- No parameters; word width fixed at 8 (1 sign, 4 exponent, 3 mantissa), operation codes and exception codes from `FPU_PACK.v`.
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  block can accept request
- FP_OPERATION  in  2  `_ADDITION`/`_SUBTRACTION`/`_MULTIPLICATION`/`_DIVISION`
- OP_A, OP_B  in  8  operands
- EXC_FP_OPERATION  out  2  registered operation driven to exception checker
- EXC_OP_A, EXC_OP_B  out  8  registered operands driven to exception checker and core
- OP_IS_EXCEPTION  in  1  from exception checker (combinational on EXC_*)
- FP_EXCE  in  3  exception code from checker
- CORE_START  out  1  one-cycle launch pulse to arithmetic core
- CORE_DONE  in  1  core result valid (single-cycle pulse)
- CORE_RESULT  in  8  core result
- RES_VALID  out  1  response valid
- RES_READY  in  1  response accepted
- RESULT  out  8  final result
- RES_EXCE  out  3  exception code for RESULT
- STATUS_FLAGS  out  4  sticky flags: [0] INVALID, [1] DIV_ZERO, [2] NAN_IN, [3] ANY_EXCE
- FLAGS_CLR  in  1  synchronous clear of STATUS_FLAGS

## Operation
- FSM states: IDLE, CHECK, EXEC, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, register operation and operands into EXC_*, then go to CHECK.
- CHECK: sample OP_IS_EXCEPTION/FP_EXCE.
  - If an exception is flagged, load the special result and go to RESP; CORE_START is never raised.
  - Otherwise go to EXEC.
- Special result:
  - `_qNAN_EXCE`, `_sNAN_EXCE`, `_INF_EXCE` → canonical qNaN 8'h7C.
  - `_ZERO_DIV_EXCE` with EXC_OP_A[6:0]==0 → 8'h7C, INVALID flag.
  - Other `_ZERO_DIV_EXCE` → signed infinity {A[7]^B[7], 7'h78}.
- EXEC:
  - CORE_START=1 in the first EXEC cycle only.
  - CORE_DONE is accepted in any EXEC cycle, including the start cycle.
  - On CORE_DONE, latch CORE_RESULT, set RES_EXCE=`_NO_EXCE`, go to RESP.
- RESP:
  - RES_VALID=1; RESULT/RES_EXCE held stable while RES_READY=0.
  - On RES_READY, go to IDLE.
- CORE_DONE outside EXEC is ignored.
- REQ_READY=0 in all states except IDLE.
- Flag setting happens on the CHECK→RESP transition:
  - INVALID ← `_sNAN_EXCE`, `_INF_EXCE`, or 0/0.
  - DIV_ZERO ← `_ZERO_DIV_EXCE` with nonzero A.
  - NAN_IN ← `_qNAN_EXCE`.
  - ANY_EXCE ← any exception.
- FLAGS_CLR clears the flags, then the same cycle's new sets are ORed in, so a simultaneous set wins.
- Reset values: state IDLE; REQ_READY=1 after reset; CORE_START=0, RES_VALID=0, RESULT=8'h00, RES_EXCE=`_NO_EXCE`, EXC_*=0, STATUS_FLAGS=4'h0.
- Reset mid-operation aborts immediately; a later stale CORE_DONE is ignored.

## Timing
- Request handshake edge = cycle 0.
- Exception path: CHECK in cycle 1, RES_VALID high from cycle 2.
- Core path: CORE_START in cycle 2. If CORE_DONE arrives in cycle 2+k, RES_VALID is high from cycle 3+k.
- Back-to-back: after the response handshake edge, REQ_READY=1 the next cycle, giving one idle cycle minimum between operations.
- STATUS_FLAGS update at the same edge RES_VALID rises.

## Configuration
- `FPU_STICKY_FLAGS_EN` defined: flags behave as above.
- `FPU_STICKY_FLAGS_EN` undefined:
  - STATUS_FLAGS port is still present, tied to 4'h0; FLAGS_CLR is ignored.
  - RESULT/RES_EXCE behaviour is unchanged.

## Structure
- `FPU_PACK.v` gains:
  - `_CANON_QNAN` (8'h7C) and `_INF_MAG` (7'h78).
  - State encodings `_ISS_IDLE`/`_ISS_CHECK`/`_ISS_EXEC`/`_ISS_RESP`.
  - Flag bit indexes `_FLG_INVALID`, `_FLG_DIV_ZERO`, `_FLG_NAN_IN`, `_FLG_ANY`.
- Sub-module: combinational `fpu_special_result`.
  - Inputs: FP_EXCE, operand A, operand B.
  - Outputs: special value and flag-set vector.
- The FSM, registers and handshakes stay in `fpu_issue_ctrl`.

## Test plan
- ADD, A=8'h78, B=8'hF8; checker returns `_INF_EXCE` → RESULT=8'h7C, RES_EXCE=`_INF_EXCE`, RES_VALID at cycle 2, CORE_START never, flags 4'b1001.
- DIV, A=8'hB8, B=8'h00 → RESULT=8'hF8, flags 4'b1010. Repeat with A=8'h00 → RESULT=8'h7C, flags 4'b1001.
- ADD, A=8'h38, B=8'h38; core raises CORE_DONE with 8'h40 three cycles after CORE_START → RESULT=8'h40, RES_EXCE=`_NO_EXCE`, RES_VALID at cycle 6, flags unchanged.
- RES_READY held low 5 cycles with a new REQ_VALID pending → RESULT stable, REQ_READY=0. Request accepted only after the response handshake plus one cycle.
- RST_N pulsed low during EXEC, CORE_DONE asserted 2 cycles after release → all outputs at reset values, no RES_VALID.
- FLAGS_CLR asserted on the cycle of a div-by-zero completion → STATUS_FLAGS=4'b1010 (prior NAN_IN cleared). Without `FPU_STICKY_FLAGS_EN`, STATUS_FLAGS stays 4'h0.
